// File: rtl/memcmd_pkg.sv
// Shared types and encodings for the memcmd_decode front end: power states,
// decoded command identifiers, pin encodings and MR0 burst-length codes.
package memcmd_pkg;

  typedef enum logic [1:0] {
    ACTIVE  = 2'd0,
    PWRDN   = 2'd1,
    SELFREF = 2'd2,
    DEEPPD  = 2'd3
  } pstate_t;

  // Values double as bit positions in the registered one-hot strobe vector.
  typedef enum logic [4:0] {
    CMD_ACT  = 5'd0,
    CMD_RD   = 5'd1,
    CMD_RDA  = 5'd2,
    CMD_WR   = 5'd3,
    CMD_WRA  = 5'd4,
    CMD_PR   = 5'd5,
    CMD_PRA  = 5'd6,
    CMD_REF  = 5'd7,
    CMD_SRF  = 5'd8,
    CMD_PD   = 5'd9,
    CMD_PDX  = 5'd10,
    CMD_DPD  = 5'd11,
    CMD_DPDX = 5'd12,
    CMD_MRW  = 5'd13,
    CMD_MRR  = 5'd14,
    CMD_BST  = 5'd15,
    CMD_NONE = 5'd16
  } cmd_t;

  localparam int unsigned NUM_STRB = 16;

  // {ras_n, cas_n, we_n} encodings with cs_n=0, act_n=1.
  localparam logic [2:0] ENC_MRS  = 3'b000;
  localparam logic [2:0] ENC_REF  = 3'b001;
  localparam logic [2:0] ENC_PRE  = 3'b010;
  localparam logic [2:0] ENC_RSVD = 3'b011;
  localparam logic [2:0] ENC_WR   = 3'b100;
  localparam logic [2:0] ENC_RD   = 3'b101;
  localparam logic [2:0] ENC_BST  = 3'b110;
  localparam logic [2:0] ENC_NOP  = 3'b111;

  // MR0 A[1:0] burst-length codes.
  localparam logic [1:0] MR0_BL8 = 2'b00;
  localparam logic [1:0] MR0_OTF = 2'b01;
  localparam logic [1:0] MR0_BC4 = 2'b10;

  // Address bits with command-specific meaning.
  localparam int unsigned A_AP  = 10;
  localparam int unsigned A_BC  = 12;
  localparam int unsigned A_MRR = 13;

  function automatic logic [NUM_STRB-1:0] cmd_onehot(input cmd_t c);
    if (c == CMD_NONE) return '0;
    return NUM_STRB'(1) << c;
  endfunction

  function automatic logic is_burst(input cmd_t c);
    return (c == CMD_RD) || (c == CMD_RDA) || (c == CMD_WR) || (c == CMD_WRA);
  endfunction

endpackage

// File: rtl/memcmd_pwr_fsm.sv
// CKE edge detector and power-state FSM. Decides power-down / self-refresh /
// deep power-down entry on a CKE falling edge from the command class sampled in
// that cycle, and produces the matching entry/exit strobe (unregistered; the
// top registers it). Deep power-down exists only when MEMCMD_DPD_EN is defined.
module memcmd_pwr_fsm
  import memcmd_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    cke,
  input  logic    ent_ref,
  input  logic    ent_idle,
  input  logic    ent_dpd,
  output logic    cke_q,
  output pstate_t pstate_q,
  output logic    cke_rise,
  output logic    cke_fall,
  output cmd_t    pwr_cmd,
  output logic    ent_bad
);

  pstate_t pstate_d;

`ifndef MEMCMD_DPD_EN
  logic unused_ent_dpd;
  assign unused_ent_dpd = ent_dpd;
`endif

  // Next power state and entry/exit strobe selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    cke_rise = ~cke_q & cke;
    cke_fall = cke_q & ~cke;
    pstate_d = pstate_q;
    pwr_cmd  = CMD_NONE;
    ent_bad  = 1'b0;
    case (pstate_q)
      ACTIVE: begin
        if (cke_fall) begin
          if (ent_ref) begin
            pwr_cmd  = CMD_SRF;
            pstate_d = SELFREF;
          end else if (ent_idle) begin
            pwr_cmd  = CMD_PD;
            pstate_d = PWRDN;
          end
`ifdef MEMCMD_DPD_EN
          else if (ent_dpd) begin
            pwr_cmd  = CMD_DPD;
            pstate_d = DEEPPD;
          end
`endif
          else begin
            // Any other command on the falling edge is dropped; still power down.
            ent_bad  = 1'b1;
            pwr_cmd  = CMD_PD;
            pstate_d = PWRDN;
          end
        end
      end
      PWRDN: begin
        if (cke_rise) begin
          pwr_cmd  = CMD_PDX;
          pstate_d = ACTIVE;
        end
      end
      SELFREF: begin
        if (cke_rise) pstate_d = ACTIVE;
      end
`ifdef MEMCMD_DPD_EN
      DEEPPD: begin
        if (cke_rise) begin
          pwr_cmd  = CMD_DPDX;
          pstate_d = ACTIVE;
        end
      end
`endif
      default: pstate_d = ACTIVE;
    endcase
  end

  // State and previous-CKE registers; reset looks like a cycle with CKE high.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      cke_q    <= 1'b1;
      pstate_q <= ACTIVE;
    end else begin
      cke_q    <= cke;
      pstate_q <= pstate_d;
    end
  end

endmodule

// File: rtl/memcmd_decode.sv
// DDR4-style command decoder front end. Samples the command/address pins each
// clock and emits registered one-cycle command strobes, the registered
// address fields of the decoded command, an MR0 burst-length shadow, and a
// sticky illegal flag with a saturating error counter. Deep power-down decode
// is enabled by defining MEMCMD_DPD_EN.
module memcmd_decode
  import memcmd_pkg::*;
#(
  parameter int unsigned BL   = 8,
  parameter int unsigned ERRW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cke,
  input  logic            cs_n,
  input  logic            act_n,
  input  logic            ras_n,
  input  logic            cas_n,
  input  logic            we_n,
  input  logic [13:0]     addr,
  input  logic [1:0]      bg,
  input  logic [1:0]      ba,
  output logic            ACT,
  output logic            RD,
  output logic            RDA,
  output logic            WR,
  output logic            WRA,
  output logic            PR,
  output logic            PRA,
  output logic            REF,
  output logic            SRF,
  output logic            PD,
  output logic            PDX,
  output logic            DPD,
  output logic            DPDX,
  output logic            MRW,
  output logic            MRR,
  output logic            BST,
  output logic            CFG,
  output logic            CKEH,
  output logic            CKEL,
  output logic [1:0]      cmd_bg,
  output logic [1:0]      cmd_ba,
  output logic [13:0]     cmd_addr,
  output logic [7:0]      bl,
  output logic [7:0]      burst_len,
  output logic            illegal,
  output logic [ERRW-1:0] err_cnt
);

  localparam logic [7:0]      BL_RST  = 8'(BL);
  localparam logic [ERRW-1:0] ERR_ONE = ERRW'(1);

  logic [2:0] enc;
  logic       cke_q;
  pstate_t    pstate_q;
  logic       cke_rise;
  logic       cke_fall;
  cmd_t       pwr_cmd;
  logic       ent_bad;
  logic       ent_ref;
  logic       ent_idle;
  logic       ent_dpd;
  logic       dec_en;
  logic       mr0_sel;

  cmd_t                dec;
  cmd_t                cmd_sel;
  logic                illegal_ev;
  logic [NUM_STRB-1:0] strb_q;
  logic                cfg_d, cfg_q;
  logic                ckeh_q, ckel_q;
  logic [1:0]          cmd_bg_d, cmd_bg_q;
  logic [1:0]          cmd_ba_d, cmd_ba_q;
  logic [13:0]         cmd_addr_d, cmd_addr_q;
  logic [7:0]          bl_d, bl_q;
  logic                otf_d, otf_q;
  logic [7:0]          blen_d, blen_q;
  logic                illegal_d, illegal_q;
  logic [ERRW-1:0]     err_d, err_q;

  assign enc      = {ras_n, cas_n, we_n};
  assign ent_ref  = ~cs_n & act_n & (enc == ENC_REF);
  assign ent_idle = cs_n | (act_n & (enc == ENC_NOP));
  assign ent_dpd  = ~cs_n & act_n & (enc == ENC_BST);
  assign dec_en   = (pstate_q == ACTIVE) & cke_q & cke & ~cs_n;
  assign mr0_sel  = (bg == 2'd0) && (ba == 2'd0);

  memcmd_pwr_fsm u_pwr (
    .clk      (clk),
    .rst      (rst),
    .cke      (cke),
    .ent_ref  (ent_ref),
    .ent_idle (ent_idle),
    .ent_dpd  (ent_dpd),
    .cke_q    (cke_q),
    .pstate_q (pstate_q),
    .cke_rise (cke_rise),
    .cke_fall (cke_fall),
    .pwr_cmd  (pwr_cmd),
    .ent_bad  (ent_bad)
  );

  // Command decode, MR0 shadow update, burst length and illegal detection.
  always_comb begin
    dec        = CMD_NONE;
    cmd_sel    = pwr_cmd;
    cfg_d      = 1'b0;
    bl_d       = bl_q;
    otf_d      = otf_q;
    blen_d     = blen_q;
    cmd_bg_d   = cmd_bg_q;
    cmd_ba_d   = cmd_ba_q;
    cmd_addr_d = cmd_addr_q;
    // Anything selected while CKE was low last cycle (incl. the exit bubble) is dropped.
    illegal_ev = ent_bad | (~cke_q & ~cs_n);
    if (dec_en) begin
      if (!act_n) begin
        dec = CMD_ACT;
      end else begin
        case (enc)
          ENC_MRS: begin
            if (addr[A_MRR]) begin
              dec = CMD_MRR;
            end else begin
              dec = CMD_MRW;
              if (mr0_sel) begin
                case (addr[1:0])
                  MR0_BL8: begin bl_d = 8'd8; otf_d = 1'b0; cfg_d = 1'b1; end
                  MR0_OTF: begin bl_d = 8'd8; otf_d = 1'b1; cfg_d = 1'b1; end
                  MR0_BC4: begin bl_d = 8'd4; otf_d = 1'b0; cfg_d = 1'b1; end
                  default: illegal_ev = 1'b1;  // reserved code, shadow kept
                endcase
              end
            end
          end
          ENC_REF:  dec = CMD_REF;
          ENC_PRE:  dec = addr[A_AP] ? CMD_PRA : CMD_PR;
          ENC_RSVD: illegal_ev = 1'b1;
          ENC_WR:   dec = addr[A_AP] ? CMD_WRA : CMD_WR;
          ENC_RD:   dec = addr[A_AP] ? CMD_RDA : CMD_RD;
          ENC_BST:  dec = CMD_BST;
          default:  dec = CMD_NONE;  // NOP
        endcase
      end
      if (dec != CMD_NONE) begin
        cmd_sel    = dec;
        cmd_bg_d   = bg;
        cmd_ba_d   = ba;
        cmd_addr_d = addr;
      end
      if (is_burst(dec)) begin
        blen_d = otf_q ? (addr[A_BC] ? 8'd8 : 8'd4) : bl_q;
      end
    end
    illegal_d = illegal_q | illegal_ev;
    err_d     = (illegal_ev && (err_q != '1)) ? err_q + ERR_ONE : err_q;
  end

  // Output and shadow registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      strb_q     <= '0;
      cfg_q      <= 1'b0;
      ckeh_q     <= 1'b0;
      ckel_q     <= 1'b0;
      cmd_bg_q   <= '0;
      cmd_ba_q   <= '0;
      cmd_addr_q <= '0;
      bl_q       <= BL_RST;
      otf_q      <= 1'b0;
      blen_q     <= BL_RST;
      illegal_q  <= 1'b0;
      err_q      <= '0;
    end else begin
      strb_q     <= cmd_onehot(cmd_sel);
      cfg_q      <= cfg_d;
      ckeh_q     <= cke_rise;
      ckel_q     <= cke_fall;
      cmd_bg_q   <= cmd_bg_d;
      cmd_ba_q   <= cmd_ba_d;
      cmd_addr_q <= cmd_addr_d;
      bl_q       <= bl_d;
      otf_q      <= otf_d;
      blen_q     <= blen_d;
      illegal_q  <= illegal_d;
      err_q      <= err_d;
    end
  end

  assign ACT       = strb_q[int'(CMD_ACT)];
  assign RD        = strb_q[int'(CMD_RD)];
  assign RDA       = strb_q[int'(CMD_RDA)];
  assign WR        = strb_q[int'(CMD_WR)];
  assign WRA       = strb_q[int'(CMD_WRA)];
  assign PR        = strb_q[int'(CMD_PR)];
  assign PRA       = strb_q[int'(CMD_PRA)];
  assign REF       = strb_q[int'(CMD_REF)];
  assign SRF       = strb_q[int'(CMD_SRF)];
  assign PD        = strb_q[int'(CMD_PD)];
  assign PDX       = strb_q[int'(CMD_PDX)];
  assign DPD       = strb_q[int'(CMD_DPD)];
  assign DPDX      = strb_q[int'(CMD_DPDX)];
  assign MRW       = strb_q[int'(CMD_MRW)];
  assign MRR       = strb_q[int'(CMD_MRR)];
  assign BST       = strb_q[int'(CMD_BST)];
  assign CFG       = cfg_q;
  assign CKEH      = ckeh_q;
  assign CKEL      = ckel_q;
  assign cmd_bg    = cmd_bg_q;
  assign cmd_ba    = cmd_ba_q;
  assign cmd_addr  = cmd_addr_q;
  assign bl        = bl_q;
  assign burst_len = blen_q;
  assign illegal   = illegal_q;
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_memcmd_decode.sv
// Testbench for memcmd_decode. Each step drives one cycle of pins and pushes
// the expected registered result; the result is popped and compared on the
// following falling clock edge. Scenario tasks add inline checks of the
// shadow and error state. Expectations for the {110}+CKE-fall case follow
// MEMCMD_DPD_EN.
module tb_memcmd_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        cke, cs_n, act_n, ras_n, cas_n, we_n;
  logic [13:0] addr;
  logic [1:0]  bg, ba;
  logic        ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX;
  logic        MRW, MRR, BST, CFG, CKEH, CKEL;
  logic [1:0]  cmd_bg, cmd_ba;
  logic [13:0] cmd_addr;
  logic [7:0]  bl, burst_len;
  logic        illegal;
  logic [7:0]  err_cnt;
  logic [18:0] obs;

  localparam logic [18:0] S_ACT  = 19'd1 << 18;
  localparam logic [18:0] S_RD   = 19'd1 << 17;
  localparam logic [18:0] S_RDA  = 19'd1 << 16;
  localparam logic [18:0] S_WR   = 19'd1 << 15;
  localparam logic [18:0] S_WRA  = 19'd1 << 14;
  localparam logic [18:0] S_PR   = 19'd1 << 13;
  localparam logic [18:0] S_PRA  = 19'd1 << 12;
  localparam logic [18:0] S_REF  = 19'd1 << 11;
  localparam logic [18:0] S_SRF  = 19'd1 << 10;
  localparam logic [18:0] S_PD   = 19'd1 << 9;
  localparam logic [18:0] S_PDX  = 19'd1 << 8;
  localparam logic [18:0] S_DPD  = 19'd1 << 7;
  localparam logic [18:0] S_DPDX = 19'd1 << 6;
  localparam logic [18:0] S_MRW  = 19'd1 << 5;
  localparam logic [18:0] S_MRR  = 19'd1 << 4;
  localparam logic [18:0] S_BST  = 19'd1 << 3;
  localparam logic [18:0] S_CFG  = 19'd1 << 2;
  localparam logic [18:0] S_CKEH = 19'd1 << 1;
  localparam logic [18:0] S_CKEL = 19'd1 << 0;

  typedef struct {
    logic [18:0] strb;
    logic [18:0] mask;
    logic        chk_ba;
    logic [1:0]  ba;
    logic        chk_bl;
    logic [7:0]  blen;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [7:0] exp_err = 8'd0;

  memcmd_decode #(.BL(8), .ERRW(8)) dut (
    .clk(clk), .rst(rst), .cke(cke), .cs_n(cs_n), .act_n(act_n),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .addr(addr), .bg(bg), .ba(ba),
    .ACT(ACT), .RD(RD), .RDA(RDA), .WR(WR), .WRA(WRA), .PR(PR), .PRA(PRA),
    .REF(REF), .SRF(SRF), .PD(PD), .PDX(PDX), .DPD(DPD), .DPDX(DPDX),
    .MRW(MRW), .MRR(MRR), .BST(BST), .CFG(CFG), .CKEH(CKEH), .CKEL(CKEL),
    .cmd_bg(cmd_bg), .cmd_ba(cmd_ba), .cmd_addr(cmd_addr), .bl(bl),
    .burst_len(burst_len), .illegal(illegal), .err_cnt(err_cnt)
  );

  assign obs = {ACT, RD, RDA, WR, WRA, PR, PRA, REF, SRF, PD, PDX, DPD, DPDX,
                MRW, MRR, BST, CFG, CKEH, CKEL};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [18:0] s, input string t);
    exp_t e;
    e.strb = s; e.mask = '1; e.chk_ba = 1'b0; e.ba = 2'd0;
    e.chk_bl = 1'b0; e.blen = 8'd0; e.tag = t;
    return e;
  endfunction

  function automatic exp_t mk_ba(input logic [18:0] s, input logic [1:0] b, input string t);
    exp_t e = mk(s, t);
    e.chk_ba = 1'b1; e.ba = b;
    return e;
  endfunction

  function automatic exp_t mk_bl(input logic [18:0] s, input logic [7:0] n, input string t);
    exp_t e = mk(s, t);
    e.chk_bl = 1'b1; e.blen = n;
    return e;
  endfunction

  task automatic bump_err();
    if (exp_err != 8'hff) exp_err = exp_err + 8'd1;
  endtask

  // Drive one cycle of pins (called at a falling edge), record the expected
  // result, then compare it once the DUT has registered it.
  task automatic step(input logic c_cke, input logic c_cs_n, input logic c_act_n,
                      input logic [2:0] c_enc, input logic [13:0] c_addr,
                      input logic [1:0] c_bg, input logic [1:0] c_ba, input exp_t e);
    exp_t got;
    cke = c_cke; cs_n = c_cs_n; act_n = c_act_n;
    {ras_n, cas_n, we_n} = c_enc;
    addr = c_addr; bg = c_bg; ba = c_ba;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    got = sb.pop_front();
    n_cmp++;
    if ((obs & got.mask) !== (got.strb & got.mask)) begin
      n_bad++;
      $display("FAIL %s strobes got %b want %b", got.tag, obs & got.mask, got.strb & got.mask);
    end
    if (got.chk_ba) begin
      n_cmp++;
      if (cmd_ba !== got.ba) begin
        n_bad++;
        $display("FAIL %s cmd_ba got %0d want %0d", got.tag, cmd_ba, got.ba);
      end
    end
    if (got.chk_bl) begin
      n_cmp++;
      if (burst_len !== got.blen) begin
        n_bad++;
        $display("FAIL %s burst_len got %0d want %0d", got.tag, burst_len, got.blen);
      end
    end
  endtask

  task automatic idle(input logic c_cke, input exp_t e);
    step(c_cke, 1'b1, 1'b1, 3'b111, 14'd0, 2'd0, 2'd0, e);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    cke = 1'b1; cs_n = 1'b1; act_n = 1'b1; {ras_n, cas_n, we_n} = 3'b111;
    addr = '0; bg = '0; ba = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    n_cmp++; if (obs !== 19'd0) begin n_bad++; $display("FAIL reset_strobes got %b want 0", obs); end
    n_cmp++; if (bl !== 8'd8) begin n_bad++; $display("FAIL reset_bl got %0d want 8", bl); end
    n_cmp++; if (burst_len !== 8'd8) begin n_bad++; $display("FAIL reset_burst_len got %0d want 8", burst_len); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_err_cnt got %0d want 0", err_cnt); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL reset_illegal got %b want 0", illegal); end
    n_cmp++; if ({cmd_bg, cmd_ba, cmd_addr} !== 18'd0) begin n_bad++; $display("FAIL reset_cmd got %h want 0", {cmd_bg, cmd_ba, cmd_addr}); end
  endtask

  task automatic test_act();
    step(1'b1, 1'b0, 1'b0, 3'b111, 14'd0, 2'd0, 2'd2, mk_ba(S_ACT, 2'd2, "act"));
    idle(1'b1, mk_ba(19'd0, 2'd2, "act_one_cycle"));
  endtask

  task automatic test_back_to_back();
    step(1'b1, 1'b0, 1'b1, 3'b101, 14'h0400, 2'd0, 2'd1, mk_bl(S_RDA, 8'd8, "rda"));
    n_cmp++; if (cmd_addr !== 14'h0400) begin n_bad++; $display("FAIL rda_cmd_addr got %h want 0400", cmd_addr); end
    step(1'b1, 1'b0, 1'b1, 3'b100, 14'h0000, 2'd1, 2'd0, mk_bl(S_WR, 8'd8, "wr"));
    n_cmp++; if (cmd_bg !== 2'd1) begin n_bad++; $display("FAIL wr_cmd_bg got %0d want 1", cmd_bg); end
    step(1'b1, 1'b0, 1'b1, 3'b010, 14'h0400, 2'd0, 2'd0, mk(S_PRA, "pra"));
    step(1'b1, 1'b0, 1'b1, 3'b110, 14'h0000, 2'd0, 2'd0, mk(S_BST, "bst"));
    step(1'b1, 1'b0, 1'b1, 3'b010, 14'h0000, 2'd0, 2'd3, mk_ba(S_PR, 2'd3, "pr"));
    step(1'b1, 1'b0, 1'b1, 3'b001, 14'h0000, 2'd0, 2'd0, mk(S_REF, "ref"));
    step(1'b1, 1'b0, 1'b1, 3'b111, 14'h0000, 2'd0, 2'd0, mk(19'd0, "nop"));
  endtask

  task automatic test_mode_reg();
    exp_t e;
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0001, 2'd0, 2'd0, mk(S_MRW | S_CFG, "mrw_otf"));
    step(1'b1, 1'b0, 1'b1, 3'b101, 14'h0000, 2'd0, 2'd0, mk_bl(S_RD, 8'd4, "rd_otf_bc4"));
    step(1'b1, 1'b0, 1'b1, 3'b101, 14'h1000, 2'd0, 2'd0, mk_bl(S_RD, 8'd8, "rd_otf_bl8"));
    step(1'b1, 1'b0, 1'b1, 3'b100, 14'h0400, 2'd0, 2'd0, mk_bl(S_WRA, 8'd4, "wra_otf_bc4"));
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0002, 2'd0, 2'd0, mk(S_MRW | S_CFG, "mrw_bc4"));
    n_cmp++; if (bl !== 8'd4) begin n_bad++; $display("FAIL mrw_bc4_bl got %0d want 4", bl); end
    step(1'b1, 1'b0, 1'b1, 3'b101, 14'h1000, 2'd0, 2'd0, mk_bl(S_RD, 8'd4, "rd_fixed4"));
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0000, 2'd0, 2'd1, mk(S_MRW, "mrw_mr1"));
    n_cmp++; if (bl !== 8'd4) begin n_bad++; $display("FAIL mrw_mr1_bl got %0d want 4", bl); end
    e = mk(S_MRW, "mrw_bad_code");
    e.mask = ~S_CFG;
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0003, 2'd0, 2'd0, e);
    bump_err();
    n_cmp++; if (bl !== 8'd4) begin n_bad++; $display("FAIL mrw_bad_bl got %0d want 4", bl); end
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL mrw_bad_illegal got %b want 1", illegal); end
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL mrw_bad_err got %0d want %0d", err_cnt, exp_err); end
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h2000, 2'd0, 2'd0, mk(S_MRR, "mrr"));
    step(1'b1, 1'b0, 1'b1, 3'b011, 14'h0000, 2'd0, 2'd0, mk(19'd0, "reserved"));
    bump_err();
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL reserved_err got %0d want %0d", err_cnt, exp_err); end
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0000, 2'd0, 2'd0, mk(S_MRW | S_CFG, "mrw_bl8"));
    n_cmp++; if (bl !== 8'd8) begin n_bad++; $display("FAIL mrw_bl8_bl got %0d want 8", bl); end
  endtask

  task automatic test_selfref();
    step(1'b0, 1'b0, 1'b1, 3'b001, 14'h0000, 2'd0, 2'd0, mk(S_SRF | S_CKEL, "srf_entry"));
    step(1'b0, 1'b0, 1'b1, 3'b101, 14'h0000, 2'd0, 2'd0, mk(19'd0, "sr_rd_dropped"));
    bump_err();
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL sr_rd_err got %0d want %0d", err_cnt, exp_err); end
    idle(1'b0, mk(19'd0, "sr_hold"));
    idle(1'b1, mk(S_CKEH, "sr_exit"));
    idle(1'b1, mk(19'd0, "sr_after"));
  endtask

  task automatic test_pwrdn();
    idle(1'b0, mk(S_PD | S_CKEL, "pd_entry"));
    idle(1'b0, mk(19'd0, "pd_hold"));
    step(1'b1, 1'b0, 1'b0, 3'b111, 14'h0000, 2'd0, 2'd1, mk(S_PDX | S_CKEH, "pd_exit_act_dropped"));
    bump_err();
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL pd_exit_err got %0d want %0d", err_cnt, exp_err); end
    idle(1'b1, mk(19'd0, "pd_after"));
    step(1'b1, 1'b0, 1'b0, 3'b111, 14'h0000, 2'd0, 2'd3, mk_ba(S_ACT, 2'd3, "act_after_pd"));
    // Illegal commands on a falling edge still enter power-down; NOP does so cleanly.
    step(1'b0, 1'b0, 1'b1, 3'b101, 14'h0000, 2'd0, 2'd0, mk(S_PD | S_CKEL, "rd_on_fall"));
    bump_err();
    idle(1'b1, mk(S_PDX | S_CKEH, "rd_on_fall_exit"));
    step(1'b0, 1'b0, 1'b1, 3'b111, 14'h0000, 2'd0, 2'd0, mk(S_PD | S_CKEL, "nop_on_fall"));
    idle(1'b1, mk(S_PDX | S_CKEH, "nop_on_fall_exit"));
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL fall_entry_err got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_deep_pd();
`ifdef MEMCMD_DPD_EN
    step(1'b0, 1'b0, 1'b1, 3'b110, 14'h0000, 2'd0, 2'd0, mk(S_DPD | S_CKEL, "dpd_entry"));
    idle(1'b0, mk(19'd0, "dpd_hold"));
    idle(1'b1, mk(S_DPDX | S_CKEH, "dpd_exit"));
`else
    step(1'b0, 1'b0, 1'b1, 3'b110, 14'h0000, 2'd0, 2'd0, mk(S_PD | S_CKEL, "dpd_off_entry"));
    bump_err();
    idle(1'b0, mk(19'd0, "dpd_off_hold"));
    idle(1'b1, mk(S_PDX | S_CKEH, "dpd_off_exit"));
`endif
    n_cmp++; if (err_cnt !== exp_err) begin n_bad++; $display("FAIL dpd_err got %0d want %0d", err_cnt, exp_err); end
  endtask

  task automatic test_reset_in_pd();
    step(1'b1, 1'b0, 1'b1, 3'b000, 14'h0002, 2'd0, 2'd0, mk(S_MRW | S_CFG, "pre_rst_mrw_bc4"));
    idle(1'b0, mk(S_PD | S_CKEL, "pre_rst_pd"));
    rst = 1'b0;
    cke = 1'b0; cs_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    exp_err = 8'd0;
    n_cmp++; if (bl !== 8'd8) begin n_bad++; $display("FAIL rst_pd_bl got %0d want 8", bl); end
    n_cmp++; if (err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_pd_err got %0d want 0", err_cnt); end
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL rst_pd_illegal got %b want 0", illegal); end
    idle(1'b0, mk(S_PD | S_CKEL, "post_rst_fall"));
    idle(1'b1, mk(S_PDX | S_CKEH, "post_rst_exit"));
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, 1'b1, 3'b011, 14'h0000, 2'd0, 2'd0, mk(19'd0, "sat_reserved"));
      bump_err();
      if (i == 253 || i == 254 || i == 299) begin
        n_cmp++;
        if (err_cnt !== exp_err) begin
          n_bad++;
          $display("FAIL sat_err_%0d got %0d want %0d", i, err_cnt, exp_err);
        end
      end
    end
    n_cmp++; if (illegal !== 1'b1) begin n_bad++; $display("FAIL sat_illegal got %b want 1", illegal); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_act();
    test_back_to_back();
    test_mode_reg();
    test_selfref();
    test_pwrdn();
    test_deep_pd();
    test_reset_in_pd();
    test_saturate();
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memcmd_decode.md
Name: memcmd_decode

Overview:
- Front-end stage that samples raw DDR4-style command/address pins once per clock.
- Decodes them into the single-cycle one-hot command strobes (ACT, RD, WR, PR, REF, SRF, PD, CKEH/CKEL, ...) consumed by the per-bank timing FSM.
- Tracks CKE power state and holds a mode-register shadow supplying burst length.
- Flags and counts illegal commands.

Parameters:
- BL, 8, reset/default burst length (beats) driven on bl.
- ERRW, 8, width of saturating illegal-command counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low (asserted when 0, sampled on posedge clk).
- cke  in  1  clock enable pin.
- cs_n  in  1  chip select, active-low.
- act_n  in  1  activate, active-low.
- ras_n  in  1  RAS/A16.
- cas_n  in  1  CAS/A15.
- we_n  in  1  WE/A14.
- addr  in  14  A[13:0]; A10=auto-precharge/all, A12=BC_n, A13=MR read select.
- bg  in  2  bank group.
- ba  in  2  bank address.
- ACT,RD,RDA,WR,WRA,PR,PRA,REF,SRF,PD,PDX,DPD,DPDX,MRW,MRR,BST,CFG,CKEH,CKEL  out  1 each  one-cycle command strobes.
- cmd_bg  out  2  registered bg of decoded command.
- cmd_ba  out  2  registered ba of decoded command.
- cmd_addr  out  14  registered addr of decoded command.
- bl  out  8  current burst length from MR0 shadow.
- burst_len  out  8  burst length of the current RD/RDA/WR/WRA strobe.
- illegal  out  1  sticky illegal-command flag.
- err_cnt  out  ERRW  saturating illegal-command count.

Behaviour:
- Reset (rst==0 at posedge):
  - all strobes 0; cmd_* 0; bl=BL; burst_len=BL; illegal=0; err_cnt=0.
  - cke_q=1; pstate=ACTIVE.
- Latency: every output is registered 1 cycle after the pins are sampled. Strobes are high for exactly one cycle.
- At most one of the command strobes is high per cycle. CKEH/CKEL may coincide with one command strobe.
- cke_q holds the previous-cycle cke. Edges: CKEL = cke_q & ~cke; CKEH = ~cke_q & cke.
- Decode when pstate==ACTIVE, cke_q==1, cke==1, cs_n==0:
  - act_n=0 -> ACT.
  - Otherwise on {ras_n,cas_n,we_n}:
    - 000: A13 ? MRR : MRW.
    - 001: REF.
    - 010: A10 ? PRA : PR.
    - 100: A10 ? WRA : WR.
    - 101: A10 ? RDA : RD.
    - 110: BST.
    - 111: NOP.
    - 011: reserved -> illegal.
- cs_n==1 is deselect (no strobe).
- MRW to MR0 (bg==0, ba==0) updates the bl shadow from A[1:0]: 00->8, 01->on-the-fly, 10->4, 11->illegal (shadow unchanged). CFG pulses in the same cycle as MRW, MR0 only.
- burst_len: fixed mode = bl. On-the-fly mode = A12 ? 8 : 4, sampled with the RD/WR.
- Power-state FSM (pstate):
  - ACTIVE to lower states, on CKE falling (cke_q=1, cke=0), decided by the command sampled that cycle:
    - REF encoding -> SRF + CKEL, pstate=SELFREF.
    - DES/NOP -> PD + CKEL, pstate=PWRDN.
    - {110} with MEMCMD_DPD_EN -> DPD + CKEL, pstate=DEEPPD.
    - Any other command -> illegal; command dropped; PD + CKEL; pstate=PWRDN.
  - PWRDN, on CKE rising -> PDX + CKEH, pstate=ACTIVE.
  - SELFREF, on CKE rising -> CKEH only, pstate=ACTIVE.
  - DEEPPD, on CKE rising -> DPDX + CKEH, pstate=ACTIVE.
  - Commands with cs_n=0 while cke_q==0 (any non-ACTIVE state) are dropped and counted illegal.
  - Command issued in the same cycle as the CKE rising edge is dropped and counted illegal (one-cycle exit bubble).
- Illegal handling: illegal goes and stays 1 until reset. err_cnt increments by 1 per illegal event and saturates at all-ones (no wrap).
- Reset mid-power-down: returns to ACTIVE with cke_q=1. A low cke on the first post-reset cycle is treated as a falling edge.

Optional Feature:
- Macro MEMCMD_DPD_EN.
- Defined: deep power-down entry/exit decode as above; DPD and DPDX are live.
- Undefined: DPD=DPDX=0 constant; DEEPPD state is absent; {110} with CKE falling is treated as illegal -> PWRDN.

Decomposition:
- Package memcmd_pkg:
  - pstate_t enum (ACTIVE, PWRDN, SELFREF, DEEPPD).
  - cmd_t enum of decoded commands.
  - localparams for the {ras,cas,we} encodings and MR0 BL codes.
- One sub-module, memcmd_pwr_fsm: CKE edge detect plus pstate, emitting entry/exit strobes.
- Top level holds the decode, the MR shadow and the error counter.

Test Plan:
- Reset low 2 cycles, release -> all strobes 0, bl=8, err_cnt=0. Then ACT (cs_n=0, act_n=0, ba=2) -> ACT=1 and cmd_ba=2 exactly one cycle later, one cycle wide.
- RD with A10=1 -> RDA; WR with A10=0 -> WR; PRE with A10=1 -> PRA; {110} -> BST. Each strobe appears alone, burst_len=8.
- MRW MR0 A[1:0]=01, then RD A12=0 -> burst_len=4; then RD A12=1 -> burst_len=8; CFG pulses once on the MRW. MRW MR0 A[1:0]=11 -> illegal=1, err_cnt=1, bl unchanged.
- REF with cke 1->0 -> SRF+CKEL. RD issued while cke=0 -> dropped, err_cnt+1. cke 0->1 -> CKEH only, no PDX.
- DES with cke falling -> PD+CKEL; cke rising -> PDX+CKEH; ACT in the same rising cycle -> dropped, illegal.
- 300 illegal events with ERRW=8 -> err_cnt saturates at 255. With MEMCMD_DPD_EN, {110} with cke falling -> DPD, cke rising -> DPDX; without the macro the same stimulus -> PD and illegal.
